// File: rtl/peg_l2_mac_pkg.sv
// Shared MAC TX definitions: framer states, preamble/SFD bytes
// and CRC-32 constants.
package peg_l2_mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_DATA = 3'd3,
    S_PAD  = 3'd4,
    S_FCS  = 3'd5,
    S_IFG  = 3'd6
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(
    input logic [31:0] v
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/peg_l2_crc32_d8.sv
// Byte-wide reflected CRC-32 update, purely combinational.
// Data bits enter LSB first, matching Ethernet bit order.
module peg_l2_crc32_d8
  import peg_l2_mac_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ POLY_R;
      else      c = c >> 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/peg_l2_mac_tx_mch_framer.sv
// Multi-channel MAC TX framer: round-robin LLC arbitration,
// preamble/SFD, padding, FCS append and inter-frame gap.
module peg_l2_mac_tx_mch_framer
  import peg_l2_mac_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int PKT_SIZE_W      = 16,
  parameter int IFG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                config_l2_mac_tx_en,
  input  logic                config_l2_mac_tx_padding_en,
  input  logic                config_l2_mac_tx_fcs_en,
  input  logic                mac_pause_en,
  input  logic [NUM_CH-1:0]   llc_tx_valid,
  input  logic [NUM_CH-1:0]   llc_tx_sop,
  input  logic [NUM_CH-1:0]   llc_tx_eop,
  input  logic [8*NUM_CH-1:0] llc_tx_data,
  output logic [NUM_CH-1:0]   llc_tx_ready,
  output logic                rs_tx_valid,
  output logic                rs_tx_sop,
  output logic                rs_tx_eop,
  output logic [7:0]          rs_tx_data,
  input  logic                rs_tx_ready,
  output logic [2:0]          l2_mac_tx_fsm_state,
  output logic [15:0]         l2_mac_tx_frm_cnt,
  output logic [15:0]         l2_mac_tx_drop_cnt
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PKT_SIZE_W-1:0] MIN_LEN =
    PKT_SIZE_W'(MIN_FRAME_BYTES);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  state_t                state_q, state_d;
  logic [7:0]            idx_q, idx_d;
  logic [PKT_SIZE_W-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [31:0]           crc_q, crc_d, crc_nx, fcs;
  logic [CW-1:0]         gnt_q, gnt_d, rr_q, rr_d;
  logic [CW-1:0]         cand_idx;
  logic                  cand_any, adv;
  logic [NUM_CH-1:0]     cand, drain;
  logic                  v_d, s_d, e_d;
  logic [7:0]            dat_d, gdat, crc_in;
  logic                  gvalid, geop;
  int                    c;

  assign adv      = !rs_tx_valid || rs_tx_ready;
  assign gvalid   = llc_tx_valid[gnt_q];
  assign geop     = llc_tx_eop[gnt_q];
  assign gdat     = llc_tx_data[{gnt_q, 3'b000} +: 8];
  assign bcnt_inc = (&bcnt_q) ? bcnt_q : bcnt_q + 1'b1;
  assign fcs      = ~crc_q;
  assign crc_in   = (state_q == S_PAD) ? 8'h00 : gdat;
  assign l2_mac_tx_fsm_state = state_q;

  peg_l2_crc32_d8 u_crc (
    .crc      (crc_q),
    .data     (crc_in),
    .crc_next (crc_nx)
  );

  // Round-robin: first sop-valid channel at or after rr_q.
  always_comb begin
    cand     = llc_tx_valid & llc_tx_sop;
    cand_any = 1'b0;
    cand_idx = '0;
    c        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(rr_q) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!cand_any && cand[c]) begin
        cand_any = 1'b1;
        cand_idx = CW'(c);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    crc_d        = crc_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    v_d          = rs_tx_valid;
    s_d          = rs_tx_sop;
    e_d          = rs_tx_eop;
    dat_d        = rs_tx_data;
    llc_tx_ready = '0;
    drain        = '0;
    if (adv) begin
      v_d = 1'b0;
      s_d = 1'b0;
      e_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          drain        = llc_tx_valid & ~llc_tx_sop;
          llc_tx_ready = drain;
          if (config_l2_mac_tx_en && !mac_pause_en
              && cand_any) begin
            gnt_d   = cand_idx;
            rr_d    = (cand_idx == CW'(NUM_CH - 1)) ?
                      '0 : cand_idx + 1'b1;
            idx_d   = '0;
            state_d = S_PRE;
          end
        end
        S_PRE: begin
          v_d   = 1'b1;
          s_d   = (idx_q == 8'd0);
          dat_d = PREAMBLE_BYTE;
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'd6) state_d = S_SFD;
        end
        S_SFD: begin
          v_d     = 1'b1;
          dat_d   = SFD_BYTE;
          bcnt_d  = '0;
          crc_d   = CRC_INIT;
          state_d = S_DATA;
        end
        S_DATA: begin
          llc_tx_ready[gnt_q] = 1'b1;
          if (gvalid) begin
            v_d    = 1'b1;
            dat_d  = gdat;
            bcnt_d = bcnt_inc;
            crc_d  = crc_nx;
            idx_d  = '0;
            if (geop) begin
              if (config_l2_mac_tx_padding_en
                  && bcnt_inc < MIN_LEN)
                state_d = S_PAD;
              else if (config_l2_mac_tx_fcs_en)
                state_d = S_FCS;
              else begin
                e_d     = 1'b1;
                state_d = S_IFG;
              end
            end
          end
        end
        S_PAD: begin
          v_d    = 1'b1;
          dat_d  = 8'h00;
          bcnt_d = bcnt_inc;
          crc_d  = crc_nx;
          idx_d  = '0;
          if (bcnt_inc >= MIN_LEN) begin
            if (config_l2_mac_tx_fcs_en)
              state_d = S_FCS;
            else begin
              e_d     = 1'b1;
              state_d = S_IFG;
            end
          end
        end
        S_FCS: begin
          v_d   = 1'b1;
          dat_d = fcs[{idx_q[1:0], 3'b000} +: 8];
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'd3) begin
            e_d     = 1'b1;
            idx_d   = '0;
            state_d = S_IFG;
          end
        end
        S_IFG: begin
          // Gap counts only once the eop beat has left.
          if (!rs_tx_valid) begin
            if (idx_q == IFG_LAST) begin
              idx_d   = '0;
              state_d = S_IDLE;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (rst) begin
      llc_tx_ready = '0;
      drain        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      idx_q              <= '0;
      bcnt_q             <= '0;
      crc_q              <= CRC_INIT;
      gnt_q              <= '0;
      rr_q               <= '0;
      rs_tx_valid        <= 1'b0;
      rs_tx_sop          <= 1'b0;
      rs_tx_eop          <= 1'b0;
      rs_tx_data         <= 8'h00;
      l2_mac_tx_frm_cnt  <= '0;
      l2_mac_tx_drop_cnt <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      crc_q       <= crc_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      rs_tx_valid <= v_d;
      rs_tx_sop   <= s_d;
      rs_tx_eop   <= e_d;
      rs_tx_data  <= dat_d;
      if (rs_tx_valid && rs_tx_ready && rs_tx_eop)
        l2_mac_tx_frm_cnt <= l2_mac_tx_frm_cnt + 16'd1;
      l2_mac_tx_drop_cnt <= l2_mac_tx_drop_cnt
                          + 16'($countones(drain));
    end
  end

endmodule

// File: tb/tb_peg_l2_mac_tx_mch_framer.sv
// Directed bench for the multi-channel MAC TX framer with a
// byte-level expected-stream model and stall stability checks.
module tb_peg_l2_mac_tx_mch_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en, pad_en, fcs_en, pause;
  logic [3:0]  llc_tx_valid, llc_tx_sop, llc_tx_eop;
  logic [3:0]  llc_tx_ready;
  logic [31:0] llc_tx_data;
  logic        rs_tx_valid, rs_tx_sop, rs_tx_eop;
  logic [7:0]  rs_tx_data;
  logic        rs_tx_ready;
  logic [2:0]  st;
  logic [15:0] frm, drop;

  always #5 clk = ~clk;

  peg_l2_mac_tx_mch_framer dut (
    .clk                         (clk),
    .rst                         (rst),
    .config_l2_mac_tx_en         (tx_en),
    .config_l2_mac_tx_padding_en (pad_en),
    .config_l2_mac_tx_fcs_en     (fcs_en),
    .mac_pause_en                (pause),
    .llc_tx_valid                (llc_tx_valid),
    .llc_tx_sop                  (llc_tx_sop),
    .llc_tx_eop                  (llc_tx_eop),
    .llc_tx_data                 (llc_tx_data),
    .llc_tx_ready                (llc_tx_ready),
    .rs_tx_valid                 (rs_tx_valid),
    .rs_tx_sop                   (rs_tx_sop),
    .rs_tx_eop                   (rs_tx_eop),
    .rs_tx_data                  (rs_tx_data),
    .rs_tx_ready                 (rs_tx_ready),
    .l2_mac_tx_fsm_state         (st),
    .l2_mac_tx_frm_cnt           (frm),
    .l2_mac_tx_drop_cnt          (drop)
  );

  logic [9:0]  src_q [4][$];
  logic [9:0]  out_q [$];
  logic [9:0]  exp_q [$];
  logic [7:0]  fb [$];
  int          gnt_log [$];
  logic [3:0]  fire;
  bit          stall_en, bub_en, prev_stall;
  logic [10:0] prev_vec;
  int          ifg_n, stall_seen;
  int          n_cmp, n_bad;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic fill(input int n, input int seed);
    fb.delete();
    for (int i = 0; i < n; i++)
      fb.push_back(8'(seed + i * 7));
  endtask

  // Queue fb on channel ch; optionally append the expected wire bytes.
  task automatic load(input int ch, input bit with_sop,
                      input bit want_exp);
    logic [31:0] c;
    logic [9:0]  t;
    int          len;
    for (int i = 0; i < fb.size(); i++)
      src_q[ch].push_back({with_sop && (i == 0),
                           i == fb.size() - 1, fb[i]});
    if (want_exp) begin
      c = 32'hFFFFFFFF;
      exp_q.push_back({2'b10, 8'h55});
      repeat (6) exp_q.push_back({2'b00, 8'h55});
      exp_q.push_back({2'b00, 8'hD5});
      for (int i = 0; i < fb.size(); i++) begin
        exp_q.push_back({2'b00, fb[i]});
        c = crc_upd(c, fb[i]);
      end
      len = fb.size();
      if (pad_en)
        while (len < 60) begin
          exp_q.push_back(10'h000);
          c = crc_upd(c, 8'h00);
          len++;
        end
      if (fcs_en) begin
        c = ~c;
        for (int j = 0; j < 4; j++)
          exp_q.push_back({2'b00, c[8*j +: 8]});
      end
      t = exp_q.pop_back();
      t[8] = 1'b1;
      exp_q.push_back(t);
    end
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_len"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ?
        out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frm == 16'(n) && st == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("wait_state", st, 0);
      chk("wait_frm", frm, n);
    end
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st == s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_st", st, s);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) src_q[k].delete();
    out_q.delete();
    exp_q.delete();
    gnt_log.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int count_bit(input int b);
    int n;
    n = 0;
    foreach (out_q[i]) if (out_q[i][b]) n++;
    return n;
  endfunction

  // Source, sink and monitor, all stepping on the falling edge.
  initial begin
    logic [3:0]  v, s, e;
    logic [31:0] d;
    llc_tx_valid = '0;
    llc_tx_sop   = '0;
    llc_tx_eop   = '0;
    llc_tx_data  = '0;
    rs_tx_ready  = 1'b0;
    fire         = '0;
    prev_stall   = 1'b0;
    prev_vec     = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (fire[k] && src_q[k].size() > 0)
          void'(src_q[k].pop_front());
      v = '0; s = '0; e = '0; d = '0;
      for (int k = 0; k < 4; k++)
        if (src_q[k].size() > 0 &&
            !(bub_en && $urandom_range(0, 1) == 0)) begin
          v[k]       = 1'b1;
          s[k]       = src_q[k][0][9];
          e[k]       = src_q[k][0][8];
          d[8*k +: 8] = src_q[k][0][7:0];
        end
      llc_tx_valid = v;
      llc_tx_sop   = s;
      llc_tx_eop   = e;
      llc_tx_data  = d;
      rs_tx_ready  = stall_en ?
                     1'($urandom_range(0, 1)) : 1'b1;
      #1;
      fire = llc_tx_valid & llc_tx_ready;
      for (int k = 0; k < 4; k++)
        if (fire[k] && llc_tx_sop[k] && st == 3'd3)
          gnt_log.push_back(k);
      if (prev_stall && !rst)
        chk("stable", {rs_tx_valid, rs_tx_sop, rs_tx_eop,
                       rs_tx_data}, prev_vec);
      prev_stall = rs_tx_valid && !rs_tx_ready && !rst;
      if (prev_stall) stall_seen++;
      prev_vec = {rs_tx_valid, rs_tx_sop, rs_tx_eop,
                  rs_tx_data};
      if (rs_tx_valid && rs_tx_ready && !rst)
        out_q.push_back({rs_tx_sop, rs_tx_eop, rs_tx_data});
      if (st == 3'd6 && !rs_tx_valid) ifg_n++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsrc;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    n_cmp = 0; n_bad = 0;
    stall_en = 0; bub_en = 0; stall_seen = 0;
    rst = 1'b1;
    tx_en = 1'b1; pad_en = 1'b1; fcs_en = 1'b1; pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", st, 0);
    chk("rst_valid", rs_tx_valid, 0);
    chk("rst_sop", rs_tx_sop, 0);
    chk("rst_eop", rs_tx_eop, 0);
    chk("rst_data", rs_tx_data, 0);
    chk("rst_ready", llc_tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_frm", frm, 0);
    chk("rst_drop", drop, 0);

    // 64-byte frame on ch0
    ifg_n = 0;
    fill(64, 16);
    load(0, 1, 1);
    wait_done(1, 400);
    chk("t1_len76", out_q.size(), 76);
    if (out_q.size() == 76) chk("t1_eop76", out_q[75][8], 1);
    cmp_stream("t1");
    chk("t1_ifg", ifg_n, 12);
    chk("t1_frm", frm, 1);

    // 10-byte frame on ch2, padded to 60
    do_rst();
    fill(10, 160);
    load(2, 1, 1);
    wait_done(1, 400);
    chk("t2_len72", out_q.size(), 72);
    cmp_stream("t2");
    chk("t2_frm", frm, 1);

    // CRC check value of "123456789"
    do_rst();
    pad_en = 1'b0;
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
    load(3, 1, 1);
    wait_done(1, 200);
    if (out_q.size() >= 4) begin
      nsrc = out_q.size();
      chk("t3_fcs0", out_q[nsrc-4][7:0], 8'h26);
      chk("t3_fcs1", out_q[nsrc-3][7:0], 8'h39);
      chk("t3_fcs2", out_q[nsrc-2][7:0], 8'hF4);
      chk("t3_fcs3", out_q[nsrc-1][7:0], 8'hCB);
    end
    cmp_stream("t3");

    // no FCS, no padding: eop on the last data byte
    do_rst();
    fcs_en = 1'b0;
    fill(5, 3);
    load(1, 1, 1);
    wait_done(1, 200);
    chk("t4_len13", out_q.size(), 13);
    cmp_stream("t4");
    fcs_en = 1'b1;

    // round-robin across all channels
    do_rst();
    fill(3, 1);  load(0, 1, 1);
    fill(3, 50); load(1, 1, 1);
    fill(3, 90); load(2, 1, 1);
    fill(3, 130); load(3, 1, 1);
    fill(3, 200); load(0, 1, 1);
    wait_done(5, 800);
    chk("t5_ngnt", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      chk($sformatf("t5_gnt%0d", i), gnt_log[i], exp_g[i]);
    cmp_stream("t5");

    // pause mid-frame
    do_rst();
    fill(20, 7);
    load(0, 1, 1);
    wait_state(3'd3, 100);
    pause = 1'b1;
    fill(5, 77);
    load(1, 1, 1);
    wait_done(1, 300);
    repeat (30) @(negedge clk);
    chk("t6_hold_st", st, 0);
    chk("t6_hold_frm", frm, 1);
    chk("t6_hold_sop", count_bit(9), 1);
    pause = 1'b0;
    wait_done(2, 300);
    cmp_stream("t6");

    // random sink stalls and source bubbles
    do_rst();
    pad_en = 1'b1;
    stall_en = 1; bub_en = 1; stall_seen = 0;
    fill(30, 11);
    load(1, 1, 1);
    wait_done(1, 3000);
    cmp_stream("t7");
    chk("t7_stalled", stall_seen != 0, 1);
    stall_en = 0; bub_en = 0;

    // sop-less bytes in IDLE are drained
    do_rst();
    fill(3, 5);
    load(1, 0, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_q[1].size() == 0) break;
    end
    repeat (5) @(negedge clk);
    chk("t8_drop", drop, 3);
    chk("t8_nout", out_q.size(), 0);
    chk("t8_st", st, 0);
    chk("t8_left", src_q[1].size(), 0);

    // reset mid-frame aborts without eop
    do_rst();
    fill(40, 9);
    load(0, 1, 0);
    wait_state(3'd3, 100);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t9_st", st, 0);
    chk("t9_valid", rs_tx_valid, 0);
    chk("t9_eop", count_bit(8), 0);
    chk("t9_frm", frm, 0);
    do_rst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/peg_l2_mac_tx_mch_framer.md
PEG_L2_MAC_TX_MCH_FRAMER -- requirements
Module: peg_l2_mac_tx_mch_framer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of LLC input channels (1..8).
REQ-002 SHALL have parameter PKT_SIZE_W, default 16, width of the byte counter.
REQ-003 SHALL have parameter IFG_BYTES, default 12, inter-frame gap in idle cycles.
REQ-004 SHALL have parameter MIN_FRAME_BYTES, default 60, minimum frame length before FCS.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports config_l2_mac_tx_en, config_l2_mac_tx_padding_en and config_l2_mac_tx_fcs_en, each input, 1, enables.
REQ-008 SHALL have port mac_pause_en, input, 1, pause request from MAC RX.
REQ-009 SHALL have ports llc_tx_valid, llc_tx_sop and llc_tx_eop, each input, NUM_CH, per-channel beat flags.
REQ-010 SHALL have port llc_tx_data, input, 8*NUM_CH, per-channel byte (channel k at bits 8k+7:8k).
REQ-011 SHALL have port llc_tx_ready, output, NUM_CH, per-channel accept.
REQ-012 SHALL have ports rs_tx_valid, rs_tx_sop and rs_tx_eop, each output, 1; port rs_tx_data, output, 8; port rs_tx_ready, input, 1.
REQ-013 SHALL have port l2_mac_tx_fsm_state, output, 3, current state encoding.
REQ-014 SHALL have ports l2_mac_tx_frm_cnt and l2_mac_tx_drop_cnt, output, 16 each, frames sent and bytes dropped.

Function
REQ-015 SHALL transfer a beat on any interface only when valid and ready are both high in the same cycle.
REQ-016 SHALL hold all rs_tx_* outputs stable while rs_tx_valid=1 and rs_tx_ready=0.
REQ-017 SHALL register rs_tx_*; output state advances when rs_tx_valid=0 or rs_tx_ready=1.
REQ-018 SHALL implement states IDLE=0, PREAMBLE=1, SFD=2, DATA=3, PAD=4, FCS=5, IFG=6.
REQ-019 IDLE->PREAMBLE SHALL occur when tx_en=1, mac_pause_en=0 and any channel has valid&sop; the grant is latched that cycle.
REQ-020 Arbitration SHALL be round-robin: search starts at the channel after the last granted one; after reset it starts at channel 0.
REQ-021 PREAMBLE SHALL emit 7 beats of 0x55, the first with rs_tx_sop=1; SFD SHALL emit one 0xD5.
REQ-022 DATA SHALL assert llc_tx_ready only for the granted channel and only when the output register can advance; no byte is consumed in any other state.
REQ-023 A granted-channel valid=0 in DATA SHALL produce rs_tx_valid=0 bubbles and no state change.
REQ-024 sop on a DATA beat after the first SHALL be ignored; eop ends DATA.
REQ-025 After eop, if padding_en=1 and byte count<MIN_FRAME_BYTES, PAD SHALL emit 0x00 until the count equals MIN_FRAME_BYTES.
REQ-026 After DATA/PAD, FCS SHALL emit 4 bytes when fcs_en=1; otherwise the last data/pad byte carries rs_tx_eop=1.
REQ-027 FCS SHALL be CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, output complemented), covering all DATA+PAD bytes, sent LSB byte first; the 4th byte carries eop.
REQ-028 IFG SHALL hold rs_tx_valid=0 for IFG_BYTES cycles, then go to IDLE; l2_mac_tx_frm_cnt increments once on the eop transfer.
REQ-029 The byte counter SHALL saturate at 2^PKT_SIZE_W-1; counters frm_cnt and drop_cnt SHALL wrap modulo 2^16.
REQ-030 In IDLE, a channel presenting valid=1 with sop=0 SHALL be drained with ready=1 and each byte SHALL increment drop_cnt; granting takes precedence when both apply on different channels.
REQ-031 mac_pause_en or tx_en deasserting mid-frame SHALL not truncate the frame; it SHALL block only the next IDLE->PREAMBLE transition.

Reset
REQ-032 On rst, state=IDLE, rs_tx_valid/sop/eop=0, rs_tx_data=0x00, llc_tx_ready=0, counters=0, RR pointer=0, CRC=0xFFFFFFFF.
REQ-033 rst mid-frame SHALL abort immediately, with no eop emitted.

Structure
REQ-034 State encoding, 0x55/0xD5 constants and CRC polynomial/init SHALL live in the shared package peg_l2_mac_pkg.
REQ-035 The byte-wide CRC-32 update SHALL be a combinational sub-module peg_l2_crc32_d8.

Verification
REQ-036 Ch0 sends a 64-byte frame, rs_tx_ready=1 -> 7x0x55, 0xD5, 64 bytes, 4 FCS bytes; eop on beat 76; then 12 idle cycles.
REQ-037 Ch2 sends a 10-byte frame with padding_en=1 -> 50 zero bytes appended; FCS covers 60 bytes; frm_cnt=1.
REQ-038 All 4 channels hold sop-valid frames -> grants in order 0,1,2,3,0.
REQ-039 mac_pause_en=1 asserted during DATA -> current frame completes; no new sop until pause=0.
REQ-040 rs_tx_ready toggles 50% with llc bubbles -> output is byte-exact vs model; rs_tx_* stable while stalled.
REQ-041 Ch1 sends 3 bytes with no sop in IDLE -> drained, drop_cnt=3, no rs_tx output.
